// File: rtl/mmu_skew_feeder_pkg.sv
// Shared definitions for the MMU feed path: FSM encodings and default array geometry,
// reused by the loader, the skew feeder and the PE array.
package mmu_skew_feeder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_ROWS   = 8;
  localparam int DEF_VEC_LEN    = 8;

endpackage

// File: rtl/mmu_skew_feeder.sv
// Read-side controller for the per-row MMU input FIFOs: drains VEC_LEN words per row with a
// diagonal skew (row r starts r steps after row 0) and registers the words for the PE array west edge.
module mmu_skew_feeder
  import mmu_skew_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_ROWS   = DEF_NUM_ROWS,
  parameter int VEC_LEN    = DEF_VEC_LEN
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_i,
  input  logic [NUM_ROWS-1:0]            fifo_empty_i,
  input  logic [NUM_ROWS*DATA_WIDTH-1:0] fifo_rdata_i,
  output logic [NUM_ROWS-1:0]            fifo_rden_o,
  output logic [NUM_ROWS*DATA_WIDTH-1:0] row_data_o,
  output logic [NUM_ROWS-1:0]            row_valid_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [1:0]                     dbg_state
);

  localparam int TOTAL = VEC_LEN + NUM_ROWS - 1;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(TOTAL - 1);

  state_e              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [31:0]         cnt_ext;
  logic [NUM_ROWS-1:0] active;
  logic [NUM_ROWS-1:0] rden;
  logic                stall;

  assign cnt_ext = 32'(cnt);

  // Row r is active for wavefront steps r .. r+VEC_LEN-1 of the drain.
  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_row
    localparam logic [31:0] LO = 32'(g);
    localparam logic [31:0] HI = 32'(g + VEC_LEN);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;

    assign active[g] = (state == S_RUN) && (cnt_ext >= LO) && (cnt_ext < HI);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= rden[g];
        if (rden[g]) data_q <= fifo_rdata_i[g*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    assign row_valid_o[g]                             = valid_q;
    assign row_data_o[g*DATA_WIDTH +: DATA_WIDTH]     = data_q;
  end

  // A single empty due FIFO freezes every row, so the diagonal skew never shears.
  assign stall       = |(active & fifo_empty_i);
  assign rden        = active & {NUM_ROWS{~stall}};
  assign fifo_rden_o = rden;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          cnt_nxt = cnt + CW'(1);
          if (cnt == LAST_STEP) state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy_o    = (state == S_RUN) || (state == S_DONE);
  assign done_o    = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mmu_skew_feeder.sv
// Bench for mmu_skew_feeder: behavioural row FIFOs, per-row expected-word scoreboard and
// pop-pattern traces for full, stalled, late-row, back-to-back and reset-abort drains.
module tb_mmu_skew_feeder;
  import mmu_skew_feeder_pkg::*;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int VL = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [NR-1:0]     fifo_empty_i;
  logic [NR*DW-1:0]  fifo_rdata_i;
  logic [NR-1:0]     fifo_rden_o;
  logic [NR*DW-1:0]  row_data_o;
  logic [NR-1:0]     row_valid_o;
  logic              busy_o;
  logic              done_o;
  logic [1:0]        dbg_state;

  mmu_skew_feeder #(.DATA_WIDTH(DW), .NUM_ROWS(NR), .VEC_LEN(VL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_rden_o  (fifo_rden_o),
    .row_data_o   (row_data_o),
    .row_valid_o  (row_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  logic [DW-1:0] fifo_q [NR][$];
  logic [DW-1:0] exp_q  [NR][$];
  logic [NR-1:0] trace[$];
  logic [NR-1:0] exp_tr[$];
  logic [NR-1:0] last_rd = '0;
  int            n_vec = 0;
  int            n_err = 0;
  int            test_id = 0;
  bit            in_drain = 1'b0;
  int            done_cnt = 0;

  function automatic logic [DW-1:0] word(input int r, input int k);
    return DW'((r << 8) | k);
  endfunction

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (test %0d): got 0x%0h expected 0x%0h", tag, test_id, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_fifo();
    for (int r = 0; r < NR; r++) begin
      fifo_empty_i[r] = (fifo_q[r].size() == 0);
      fifo_rdata_i[r*DW +: DW] = (fifo_q[r].size() != 0) ? fifo_q[r][0] : '0;
    end
  endtask

  task automatic load_row(input int r, input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) begin
      fifo_q[r].push_back(word(r, k));
      exp_q[r].push_back(word(r, k));
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < NR; r++) begin
      fifo_q[r].delete();
      exp_q[r].delete();
    end
    last_rd = '0;
  endtask

  // One clock: retire last cycle's pops, apply late pushes, check registered outputs, sample pops.
  task automatic cycle();
    @(negedge clk);
    for (int r = 0; r < NR; r++)
      if (last_rd[r] && fifo_q[r].size() != 0) void'(fifo_q[r].pop_front());
    if (test_id == 3 && in_drain && trace.size() == 8 && fifo_q[1].size() == 0) load_row(1, 2, 2);
    if (test_id == 4 && in_drain && trace.size() == 3 && fifo_q[3].size() == 0) load_row(3, 0, 4);
    drive_fifo();
    #1;
    for (int r = 0; r < NR; r++) begin
      if (row_valid_o[r]) begin
        if (exp_q[r].size() == 0)
          check_eq($sformatf("row%0d_unexpected_word", r), 32'(exp_q[r].size()), 32'd1);
        else
          check_eq($sformatf("row%0d_data", r), row_data_o[r*DW +: DW], exp_q[r].pop_front());
      end
      if (fifo_rden_o[r]) check_eq($sformatf("row%0d_pop_nonempty", r), 32'(fifo_empty_i[r]), 32'd0);
    end
    if (done_o) begin
      done_cnt++;
      check_eq("done_last_lane_valid", 32'(row_valid_o), 32'b1000);
      check_eq("done_busy", 32'(busy_o), 32'd1);
    end
    last_rd = fifo_rden_o;
    if (in_drain) trace.push_back(fifo_rden_o);
  endtask

  task automatic run_drain(input bit hold, output int ncyc);
    int d0;
    d0 = done_cnt;
    trace.delete();
    start_i  = 1'b1;
    in_drain = 1'b1;
    ncyc = 0;
    while (done_cnt == d0 && ncyc < 60) begin
      cycle();
      ncyc++;
      if (!hold) start_i = 1'b0;
    end
    in_drain = 1'b0;
    check_eq("drain_done_once", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic compare_trace(input string tag);
    check_eq({tag, "_len"}, 32'(trace.size()), 32'(exp_tr.size()));
    for (int i = 0; i < exp_tr.size() && i < trace.size(); i++)
      check_eq($sformatf("%s_rden[%0d]", tag, i), 32'(trace[i]), 32'(exp_tr[i]));
  endtask

  task automatic set_full_trace();
    exp_tr = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
  endtask

  task automatic check_all_idle(input string tag);
    check_eq({tag, "_rden"},  32'(fifo_rden_o), 32'd0);
    check_eq({tag, "_valid"}, 32'(row_valid_o), 32'd0);
    check_eq({tag, "_data"},  row_data_o[DW-1:0] | row_data_o[2*DW-1:DW] |
                              row_data_o[3*DW-1:2*DW] | row_data_o[4*DW-1:3*DW], 32'd0);
    check_eq({tag, "_busy"},  32'(busy_o), 32'd0);
    check_eq({tag, "_done"},  32'(done_o), 32'd0);
  endtask

  task automatic check_drained(input string tag);
    for (int r = 0; r < NR; r++) begin
      check_eq($sformatf("%s_row%0d_words_left", tag, r), 32'(exp_q[r].size()), 32'd0);
      check_eq($sformatf("%s_row%0d_fifo_left", tag, r), 32'(fifo_q[r].size()), 32'd0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus + final report ----------------
  initial begin
    int n1, n2;
    clear_model();
    drive_fifo();

    // 1) reset, then idle with start_i low
    test_id = 1;
    #1;
    check_all_idle("reset");
    check_eq("reset_state", 32'(dbg_state), 32'(S_IDLE));
    repeat (2) cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_all_idle("idle");
    end

    // 2) all FIFOs prefilled, single start pulse
    test_id = 2;
    for (int r = 0; r < NR; r++) load_row(r, 0, VL);
    run_drain(1'b0, n1);
    set_full_trace();
    compare_trace("full");
    check_eq("full_cycles", 32'(n1), 32'd8);
    cycle();
    check_eq("full_back_idle", 32'(dbg_state), 32'(S_IDLE));
    check_drained("full");

    // 3) row 1 runs dry after two words; refill arrives after a 5-cycle stall
    test_id = 3;
    for (int r = 0; r < NR; r++) load_row(r, 0, (r == 1) ? 2 : VL);
    run_drain(1'b0, n1);
    exp_tr = '{4'b0001, 4'b0011, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
               4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    compare_trace("stall");
    cycle();
    check_drained("stall");

    // 4) row 3 empty until it becomes active: no stall expected
    test_id = 4;
    for (int r = 0; r < NR - 1; r++) load_row(r, 0, VL);
    run_drain(1'b0, n1);
    set_full_trace();
    compare_trace("late_row");
    cycle();
    check_drained("late_row");

    // 5) start held through RUN, DONE and the following IDLE cycle
    test_id = 5;
    for (int r = 0; r < NR; r++) load_row(r, 0, 2 * VL);
    run_drain(1'b1, n1);
    set_full_trace();
    compare_trace("held_first");
    cycle();
    check_eq("held_idle_gap_busy", 32'(busy_o), 32'd0);
    check_eq("held_idle_gap_state", 32'(dbg_state), 32'(S_IDLE));
    run_drain(1'b0, n2);
    compare_trace("held_second");
    check_eq("held_second_cycles", 32'(n2), 32'd8);
    cycle();
    check_eq("held_no_third_drain", 32'(busy_o), 32'd0);
    check_drained("held");

    // 6) asynchronous reset mid-drain, then a clean drain
    test_id = 6;
    for (int r = 0; r < NR; r++) load_row(r, 0, VL);
    start_i  = 1'b1;
    in_drain = 1'b1;
    trace.delete();
    cycle();
    start_i = 1'b0;
    repeat (2) cycle();
    in_drain = 1'b0;
    exp_tr = '{4'b0001, 4'b0011, 4'b0111};
    compare_trace("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check_all_idle("async_reset");
    check_eq("async_reset_state", 32'(dbg_state), 32'(S_IDLE));
    clear_model();
    drive_fifo();
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    check_all_idle("post_reset");
    for (int r = 0; r < NR; r++) load_row(r, 0, VL);
    run_drain(1'b0, n1);
    set_full_trace();
    compare_trace("after_reset");
    cycle();
    check_drained("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
